i2c_slave_tx_sequencer: RTL

Controls the slave transmit phase of an I2C read transaction. Fetches bytes from an upstream byte source and drives the I2C_slave_write bit/byte engine through its wr_en/is_byte/wr_ld/wr_finish handshake. After each byte it uses a companion 1-bit read engine to sample the master ACK/NACK. Sits between the slave top-level FSM (address match, R/W decode) and the SDA/SCL engines, and reports completion, NACK and error causes.

---
 rtl/i2c_slave_tx_sequencer.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_tx_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_slave_tx_sequencer
//
// Purpose: sequences the slave-transmit phase of an I2C read. Pulls bytes from
// an upstream byte source, streams them MSB first into the bit/byte write
// engine, then hands over to a 1-bit read engine to sample the master
// ACK/NACK. A master ACK fetches the next byte; a NACK ends the phase
// normally. START/STOP/bus errors and write-engine drive errors abort it.
//
// Optional build macro: I2C_TX_TIMEOUT_EN
//   defined   -> SEND/ACK abort with err_code 4 after TIMEOUT_CYCLES clocks
//                without engine progress (wr_ld, wr_finish or rd_finish)
//   undefined -> no timeout logic; TIMEOUT_CYCLES is unused
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   start_tx_i          begin transmit phase (only accepted in IDLE)
//   tx_valid_i/tx_data_i/tx_ready_o   upstream byte source handshake
//   wr_en_o/is_byte_o/wr_data_o       write engine control, serial data
//   wr_ld_i/wr_finish_i/wr_err_i      write engine shift / done / drive error
//   rd_en_o/rd_finish_i/rd_data_i     1-bit read engine for master ACK
//   get_start_i/get_stop_i/bus_err_i  bus condition detectors
//   busy_o/done_o/err_o/err_code_o    status; err_code held until next start
//   underflow_o         sticky: FILL_BYTE was transmitted
//   byte_cnt_o          bytes completed (ACK or NACK seen), saturating
//
// All outputs come straight from flops.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start_tx
// S_FETCH | one cycle: accept a byte (or FILL_BYTE on underflow)
// S_SEND  | write engine shifting the byte out
// S_ACK   | read engine sampling master ACK/NACK
// S_DONE  | one-cycle done pulse (master NACK)
// S_ERR   | one-cycle err pulse, err_code valid
// ---------------------------------------------------------------------------
module i2c_slave_tx_sequencer #(
    parameter logic [7:0] FILL_BYTE      = 8'hFF,
    parameter int         CNT_W          = 8,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tx_i,
    input  logic             tx_valid_i,
    input  logic [7:0]       tx_data_i,
    output logic             tx_ready_o,
    output logic             wr_en_o,
    output logic             is_byte_o,
    output logic             wr_data_o,
    input  logic             wr_ld_i,
    input  logic             wr_finish_i,
    input  logic             wr_err_i,
    output logic             rd_en_o,
    input  logic             rd_finish_i,
    input  logic             rd_data_i,
    input  logic             get_start_i,
    input  logic             get_stop_i,
    input  logic             bus_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       err_code_o,
    output logic             underflow_o,
    output logic [CNT_W-1:0] byte_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_ACK   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [2:0]       CODE_WR_ERR  = 3'd1;
    localparam logic [2:0]       CODE_BUS_EVT = 3'd2;
    localparam logic [2:0]       CODE_BUS_ERR = 3'd3;
    localparam logic [2:0]       CODE_TIMEOUT = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uf_q, uf_d;
    logic [2:0]       code_q, code_d;

    logic             in_xfer;
    logic             timeout;
    logic [2:0]       abort_code;
    logic             abort;

    logic tx_ready_q, tx_ready_d;
    logic wr_en_q, wr_en_d;
    logic wr_data_q, wr_data_d;
    logic rd_en_q, rd_en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    assign in_xfer = (state_q == S_FETCH) || (state_q == S_SEND) || (state_q == S_ACK);

    // Abort sources in priority order; an abort wins over a same-cycle
    // wr_finish/rd_finish so the in-flight byte is never counted.
    always_comb begin
        abort_code = 3'd0;
        if (in_xfer) begin
            if (bus_err_i)
                abort_code = CODE_BUS_ERR;
            else if (get_start_i || get_stop_i)
                abort_code = CODE_BUS_EVT;
            else if (wr_err_i)
                abort_code = CODE_WR_ERR;
            else if (timeout)
                abort_code = CODE_TIMEOUT;
        end
    end

    assign abort = (abort_code != 3'd0);

`ifdef I2C_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             progress;
    logic             in_wait;

    assign progress = wr_ld_i | wr_finish_i | rd_finish_i;
    assign in_wait  = (state_q == S_SEND) || (state_q == S_ACK);
    assign timeout  = in_wait && !progress && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Restarts on every state change (including entry) and on engine progress.
    assign tmo_d = (in_wait && (state_d == state_q) && !progress) ? tmo_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_tx_i)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = abort ? S_ERR : S_SEND;
            end
            S_SEND: begin
                if (abort)
                    state_d = S_ERR;
                else if (wr_finish_i)
                    state_d = S_ACK;
            end
            S_ACK: begin
                if (abort)
                    state_d = S_ERR;
                else if (rd_finish_i)
                    state_d = rd_data_i ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: shift register, byte counter, sticky status
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        uf_d    = uf_q;
        code_d  = code_q;

        if (state_q == S_IDLE && start_tx_i) begin
            cnt_d  = '0;
            uf_d   = 1'b0;
            code_d = 3'd0;
        end

        // tx_ready is already high in FETCH, so the source byte is consumed
        // even if the phase aborts this cycle; only a real send marks underflow.
        if (state_q == S_FETCH) begin
            shift_d = tx_valid_i ? tx_data_i : FILL_BYTE;
            if (!tx_valid_i && !abort)
                uf_d = 1'b1;
        end

        if (state_q == S_SEND && wr_ld_i)
            shift_d = {shift_q[6:0], 1'b0};

        if (state_q == S_ACK && rd_finish_i && !abort && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;

        if (abort)
            code_d = abort_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 8'h00;
            cnt_q   <= '0;
            uf_q    <= 1'b0;
            code_q  <= 3'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            uf_q    <= uf_d;
            code_q  <= code_d;
        end
    end

    // FSM: output logic, decoded from the next state so the flopped outputs
    // line up with the state they describe.
    always_comb begin
        tx_ready_d = (state_d == S_FETCH);
        wr_en_d    = (state_d == S_SEND);
        wr_data_d  = (state_d == S_SEND) && shift_d[7];
        rd_en_d    = (state_d == S_ACK);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_ready_q <= tx_ready_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Byte mode is always used for the transmit phase, so it tracks wr_en.
    assign tx_ready_o  = tx_ready_q;
    assign wr_en_o     = wr_en_q;
    assign is_byte_o   = wr_en_q;
    assign wr_data_o   = wr_data_q;
    assign rd_en_o     = rd_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign underflow_o = uf_q;
    assign byte_cnt_o  = cnt_q;

endmodule
